// File: rtl/fpu_pkg.sv
// Shared FP definitions: widths, fflags bit positions, rounding-mode encodings and register index type.
// Used by the FP write-back stage and its arbiter.
package fpu_pkg;

   localparam int FLEN_DEFAULT = 32;
   localparam int NREG_DEFAULT = 32;

   localparam int FF_NV = 4;
   localparam int FF_DZ = 3;
   localparam int FF_OF = 2;
   localparam int FF_UF = 1;
   localparam int FF_NX = 0;

   typedef enum logic [2:0] {
      FRM_RNE = 3'd0,
      FRM_RTZ = 3'd1,
      FRM_RDN = 3'd2,
      FRM_RUP = 3'd3,
      FRM_RMM = 3'd4,
      FRM_DYN = 3'd7
   } frm_e;

   typedef logic [4:0] reg_idx_t;

   // Low byte of fcsr; the upper 24 bits are hard-wired zero.
   typedef struct packed {
      logic [2:0] frm;
      logic [4:0] fflags;
   } fcsr_lo_t;

   function automatic logic [4:0] accrue_flags(input logic [4:0] cur, input logic [4:0] add);
      return cur | add;
   endfunction

endpackage

// File: rtl/fp_writeback_rr_arb2.sv
// Two-requester round-robin arbiter, req[0] (EX) preferred out of reset.
// Grant is combinational from req; the pointer only toggles after a contested grant.
module rr_arb2 (
   input  logic       clk,
   input  logic       resetn,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic ptr_q;
   logic ptr_d;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   always_comb begin
      gnt   = 2'b00;
      ptr_d = ptr_q;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11: begin
            gnt   = ptr_q ? 2'b10 : 2'b01;
            ptr_d = ~ptr_q;
         end
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/fp_writeback.sv
// FP write-back: arbitrates EX/load results into the register array, keeps fcsr flags and pending scoreboard.
// One-cycle accept-to-write latency; whenever any source is valid exactly one is granted, the loser sees ready low.
module fp_writeback
   import fpu_pkg::*;
#(
   parameter int FLEN = FLEN_DEFAULT,
   parameter int NREG = NREG_DEFAULT
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            ex_valid,
   output logic            ex_ready,
   input  logic [4:0]      ex_rd,
   input  logic [FLEN-1:0] ex_data,
   input  logic [4:0]      ex_fflags,
   input  logic            ld_valid,
   output logic            ld_ready,
   input  logic [4:0]      ld_rd,
   input  logic [FLEN-1:0] ld_data,
   input  logic            iss_valid,
   input  logic [4:0]      iss_rd,
   input  logic            csr_we,
   input  logic [7:0]      csr_wdata,
   output logic [FLEN-1:0] G,
   output logic [NREG-1:0] F_in,
   output logic [31:0]     fcsr,
   output logic [NREG-1:0] pending
);

   typedef struct packed {
      reg_idx_t        rd;
      logic [FLEN-1:0] data;
   } wb_t;

   logic [1:0]      gnt;
   logic            accept;
   wb_t             sel;

   logic [FLEN-1:0] g_q,       g_d;
   logic [NREG-1:0] f_in_q,    f_in_d;
   fcsr_lo_t        fcsr_q,    fcsr_d;
   logic [NREG-1:0] pending_q, pending_d;

   rr_arb2 u_arb (
      .clk    (clk),
      .resetn (resetn),
      .req    ({ld_valid, ex_valid}),
      .gnt    (gnt)
   );

   assign ex_ready = gnt[0];
   assign ld_ready = gnt[1];
   assign accept   = |gnt;

   always_comb begin
      sel = '{rd: ex_rd, data: ex_data};
      if (gnt[1]) begin
         sel = '{rd: ld_rd, data: ld_data};
      end
   end

   // G holds its last value when idle; only F_in qualifies a write.
   always_comb begin
      g_d    = g_q;
      f_in_d = '0;
      if (accept) begin
         g_d = sel.data;
      end
      for (int i = 0; i < NREG; i++) begin
         f_in_d[i] = accept && (sel.rd == reg_idx_t'(i));
      end
   end

   // Software write lands first so that flags accrued in the same cycle survive it.
   always_comb begin
      fcsr_d = fcsr_q;
      if (csr_we) begin
         fcsr_d = fcsr_lo_t'(csr_wdata);
      end
      if (ex_ready) begin
         fcsr_d.fflags = accrue_flags(fcsr_d.fflags, ex_fflags);
      end
   end

   // Clear on write-back, then set on issue, so a same-cycle issue to the same rd stays pending.
   always_comb begin
      pending_d = pending_q;
      for (int i = 0; i < NREG; i++) begin
         if (accept && (sel.rd == reg_idx_t'(i))) begin
            pending_d[i] = 1'b0;
         end
         if (iss_valid && (iss_rd == reg_idx_t'(i))) begin
            pending_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         g_q       <= '0;
         f_in_q    <= '0;
         fcsr_q    <= '0;
         pending_q <= '0;
      end else begin
         g_q       <= g_d;
         f_in_q    <= f_in_d;
         fcsr_q    <= fcsr_d;
         pending_q <= pending_d;
      end
   end

   assign G       = g_q;
   assign F_in    = f_in_q;
   assign fcsr    = {24'b0, fcsr_q};
   assign pending = pending_q;

endmodule

// File: tb/tb_fp_writeback.sv
// Directed bench for fp_writeback: an abstract per-cycle model checked every cycle plus literal expectations.
module tb_fp_writeback;

   localparam int FLEN = 32;
   localparam int NREG = 32;

   logic            clk = 1'b0;
   logic            resetn = 1'b0;
   logic            ex_valid = 1'b0;
   logic            ex_ready;
   logic [4:0]      ex_rd = '0;
   logic [FLEN-1:0] ex_data = '0;
   logic [4:0]      ex_fflags = '0;
   logic            ld_valid = 1'b0;
   logic            ld_ready;
   logic [4:0]      ld_rd = '0;
   logic [FLEN-1:0] ld_data = '0;
   logic            iss_valid = 1'b0;
   logic [4:0]      iss_rd = '0;
   logic            csr_we = 1'b0;
   logic [7:0]      csr_wdata = '0;
   logic [FLEN-1:0] G;
   logic [NREG-1:0] F_in;
   logic [31:0]     fcsr;
   logic [NREG-1:0] pending;

   always #5 clk = ~clk;

   fp_writeback #(.FLEN(FLEN), .NREG(NREG)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .ex_valid  (ex_valid),
      .ex_ready  (ex_ready),
      .ex_rd     (ex_rd),
      .ex_data   (ex_data),
      .ex_fflags (ex_fflags),
      .ld_valid  (ld_valid),
      .ld_ready  (ld_ready),
      .ld_rd     (ld_rd),
      .ld_data   (ld_data),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .csr_we    (csr_we),
      .csr_wdata (csr_wdata),
      .G         (G),
      .F_in      (F_in),
      .fcsr      (fcsr),
      .pending   (pending)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model state: what the outputs must be after the most recent edge.
   bit        m_ld_first;
   bit [31:0] m_pend, m_g, m_f;
   bit [7:0]  m_csr;
   bit        n_ld_first;
   bit [31:0] n_pend, n_g, n_f;
   bit [7:0]  n_csr;
   bit        have_nxt;

   task automatic m_reset();
      m_ld_first = 1'b0;
      m_pend     = '0;
      m_g        = '0;
      m_f        = '0;
      m_csr      = '0;
   endtask

   initial begin
      bit eg, lg;
      m_reset();
      forever begin
         @(negedge clk);
         have_nxt = 1'b0;
         if (resetn) begin
            if (ex_valid && ld_valid) begin
               eg = !m_ld_first;
               lg = m_ld_first;
               n_ld_first = !m_ld_first;
            end else begin
               eg = ex_valid;
               lg = ld_valid;
               n_ld_first = m_ld_first;
            end
            chk("ex_ready", {31'b0, ex_ready}, {31'b0, eg});
            chk("ld_ready", {31'b0, ld_ready}, {31'b0, lg});
            n_g    = m_g;
            n_f    = '0;
            n_csr  = m_csr;
            n_pend = m_pend;
            if (eg) begin
               n_g = ex_data;
               n_f = 32'd1 << ex_rd;
               n_pend[ex_rd] = 1'b0;
            end
            if (lg) begin
               n_g = ld_data;
               n_f = 32'd1 << ld_rd;
               n_pend[ld_rd] = 1'b0;
            end
            if (csr_we) n_csr = csr_wdata;
            if (eg) n_csr[4:0] = n_csr[4:0] | ex_fflags;
            if (iss_valid) n_pend[iss_rd] = 1'b1;
            have_nxt = 1'b1;
         end
         @(posedge clk);
         #1;
         if (!resetn) begin
            m_reset();
         end else if (have_nxt) begin
            m_ld_first = n_ld_first;
            m_g        = n_g;
            m_f        = n_f;
            m_csr      = n_csr;
            m_pend     = n_pend;
         end
         chk("G", G, m_g);
         chk("F_in", F_in, m_f);
         chk("F_in_onehot0", {31'b0, $onehot0(F_in)}, 32'd1);
         chk("fcsr", fcsr, {24'b0, m_csr});
         chk("pending", pending, m_pend);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      tick();
      chk("rst_G", G, 32'h0);
      chk("rst_F_in", F_in, 32'h0);
      chk("rst_fcsr", fcsr, 32'h0);
      chk("rst_pending", pending, 32'h0);
      resetn = 1'b1;
      tick();

      // EX only
      ex_valid = 1'b1; ex_rd = 5'd3; ex_data = 32'h3F800000; ex_fflags = 5'b00001;
      #1 chk("exonly_ready", {31'b0, ex_ready}, 32'd1);
      tick();
      ex_valid = 1'b0; ex_fflags = '0;
      chk("exonly_F_in", F_in, 32'h8);
      chk("exonly_G", G, 32'h3F800000);
      chk("exonly_fcsr", fcsr, 32'h01);
      tick();
      chk("exonly_pulse_end", F_in, 32'h0);

      // Contention: EX, LD, EX, LD
      ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 32'hAAAA0005;
      ld_valid = 1'b1; ld_rd = 5'd6; ld_data = 32'h55550006;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("cont_ex_ready", {31'b0, ex_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
         chk("cont_ld_ready", {31'b0, ld_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
         tick();
         chk("cont_F_in", F_in, (k % 2 == 0) ? 32'h20 : 32'h40);
         chk("cont_G", G, (k % 2 == 0) ? 32'hAAAA0005 : 32'h55550006);
      end
      ex_valid = 1'b0; ld_valid = 1'b0;
      tick();

      // Flags
      csr_we = 1'b1; csr_wdata = 8'h00;
      tick();
      csr_we = 1'b0;
      chk("flags_clear", fcsr, 32'h0);
      ex_valid = 1'b1; ex_rd = 5'd1; ex_data = 32'h7FC00000; ex_fflags = 5'b10000;
      tick();
      ex_valid = 1'b0; ex_fflags = '0;
      ld_valid = 1'b1; ld_rd = 5'd2; ld_data = 32'h12345678;
      tick();
      ld_valid = 1'b0;
      chk("flags_after_ld", fcsr, 32'h10);
      ex_valid = 1'b1; ex_rd = 5'd1; ex_data = 32'h7F800000; ex_fflags = 5'b01000;
      tick();
      ex_valid = 1'b0; ex_fflags = '0;
      chk("flags_nv_dz", fcsr, 32'h18);
      csr_we = 1'b1; csr_wdata = 8'h20;
      ex_valid = 1'b1; ex_rd = 5'd4; ex_data = 32'h3EAAAAAB; ex_fflags = 5'b00001;
      tick();
      csr_we = 1'b0; ex_valid = 1'b0; ex_fflags = '0;
      chk("flags_csr_we_nx", fcsr, 32'h21);

      // Scoreboard
      iss_valid = 1'b1; iss_rd = 5'd7;
      tick();
      iss_valid = 1'b0;
      chk("sb_set", pending, 32'h80);
      ex_valid = 1'b1; ex_rd = 5'd7; ex_data = 32'h11111111;
      tick();
      ex_valid = 1'b0;
      chk("sb_clear", pending, 32'h0);
      iss_valid = 1'b1; iss_rd = 5'd7;
      ex_valid = 1'b1; ex_rd = 5'd7; ex_data = 32'h22222222;
      tick();
      iss_valid = 1'b0;
      chk("sb_set_wins", pending, 32'h80);
      chk("sb_set_wins_F_in", F_in, 32'h80);
      ex_data = 32'h40490FDB;
      tick();
      ex_valid = 1'b0;
      chk("sb_clear2", pending, 32'h0);

      // Idle
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("idle_F_in", F_in, 32'h0);
         chk("idle_G", G, 32'h40490FDB);
      end

      // Reset mid-operation; the contested grant leaves the pointer on LD first
      ex_valid = 1'b1; ex_rd = 5'd10; ex_data = 32'hCAFE000A; ex_fflags = 5'b00100;
      ld_valid = 1'b1; ld_rd = 5'd11; ld_data = 32'hBEEF000B;
      iss_valid = 1'b1; iss_rd = 5'd9;
      tick();
      iss_valid = 1'b0;
      chk("pre_rst_F_in", F_in, 32'h400);
      #1 resetn = 1'b0;
      #1;
      chk("arst_G", G, 32'h0);
      chk("arst_F_in", F_in, 32'h0);
      chk("arst_fcsr", fcsr, 32'h0);
      chk("arst_pending", pending, 32'h0);
      tick();
      resetn = 1'b1;
      #1;
      chk("post_rst_ex_ready", {31'b0, ex_ready}, 32'd1);
      chk("post_rst_ld_ready", {31'b0, ld_ready}, 32'd0);
      tick();
      chk("post_rst_F_in", F_in, 32'h400);
      chk("post_rst_fcsr", fcsr, 32'h04);
      ex_valid = 1'b0; ld_valid = 1'b0; ex_fflags = '0;
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
